// File: rtl/perf_counter_bank.sv
// perf_counter_bank: bank of NUM_CH event counters with run/freeze control,
// atomic snapshot into shadow registers and a registered shadow read port.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   reset_n  : asynchronous active-low reset
//   inc      : per-channel event pulses, +1 per high cycle while running
//   start    : begin / resume counting
//   stop     : freeze counting
//   clear    : synchronous zero of live counters and overflow flags
//   snap     : copy every live counter into its shadow register
//   rd_sel   : shadow channel select
//   rd_data  : registered shadow[rd_sel], 0 for selects beyond NUM_CH-1
//   running  : high while in RUN
//   ovf      : sticky per-channel overflow flags

// One counter channel: live count, sticky overflow and snapshot shadow.
module perf_ctr_ch #(
  parameter int WIDTH    = 32,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clear,
  input  logic             snap,
  output logic [WIDTH-1:0] shadow,
  output logic             ovf
);
  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      shadow <= '0;
      ovf    <= 1'b0;
    end else begin
      // Shadow takes the pre-update count, so a snap coinciding with an
      // increment or clear still captures a consistent cross-channel image.
      if (snap) shadow <= cnt;
      if (clear) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (en) begin
        if (&cnt) begin
          ovf <= 1'b1;
          cnt <= (SATURATE != 0) ? cnt : '0;
        end else begin
          cnt <= cnt + WIDTH'(1);
        end
      end
    end
  end
endmodule

module perf_counter_bank #(
  parameter int NUM_CH    = 6,
  parameter int WIDTH     = 32,
  parameter int SATURATE  = 0,
  parameter int CYCLE_CH0 = 1,
  localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] inc,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              snap,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [WIDTH-1:0]  rd_data,
  output logic              running,
  output logic [NUM_CH-1:0] ovf
);
  typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

  state_t state_q, state_d;
  logic   count_en;

  logic [NUM_CH-1:0][WIDTH-1:0] shadow;
  logic [NUM_CH-1:0]            ch_ev;
  logic [NUM_CH-1:0]            ch_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    count_en = 1'b0;
    if (clear) begin
      state_d = start ? RUN : IDLE;
    end else if (start && stop) begin
      state_d = state_q;
    end else if (start) begin
      state_d = RUN;
    end else if (stop && state_q == RUN) begin
      state_d = FROZEN;
    end
    // Count only on cycles that start and stay in RUN: a stop in this cycle
    // discards this cycle's events, and clear overrides any increment.
    count_en = (state_q == RUN) && (state_d == RUN) && !clear;
  end

  assign running = (state_q == RUN);

  // Channel 0 optionally counts every running cycle instead of inc[0].
  assign ch_ev = inc | NUM_CH'(CYCLE_CH0 != 0);
  assign ch_en = ch_ev & {NUM_CH{count_en}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    perf_ctr_ch #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (ch_en[i]),
      .clear   (clear),
      .snap    (snap),
      .shadow  (shadow[i]),
      .ovf     (ovf[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  rd_data <= '0;
    else if (int'(rd_sel) < NUM_CH) rd_data <= shadow[rd_sel];
    else                           rd_data <= '0;
  end
endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank. Three configurations run in
// lockstep on shared stimulus: 32-bit wrap with cycle ch0, 8-bit wrap with
// cycle ch0, 8-bit saturate with ch0 driven by inc[0]. A spec-level model
// tracks counters as plain integers modulo 2**WIDTH.
module tb_perf_counter_bank;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] inc = '0;
  logic       start = 1'b0, stop = 1'b0, clear = 1'b0, snap = 1'b0;
  logic [2:0] rd_sel = '0;

  logic [31:0] rd_a;
  logic [7:0]  rd_w, rd_s;
  logic        run_a, run_w, run_s;
  logic [5:0]  ovf_a, ovf_w, ovf_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CH(6), .WIDTH(32), .SATURATE(0), .CYCLE_CH0(1)) u_a (
    .clk(clk), .reset_n(reset_n), .inc(inc), .start(start), .stop(stop),
    .clear(clear), .snap(snap), .rd_sel(rd_sel), .rd_data(rd_a),
    .running(run_a), .ovf(ovf_a));
  perf_counter_bank #(.NUM_CH(6), .WIDTH(8), .SATURATE(0), .CYCLE_CH0(1)) u_w (
    .clk(clk), .reset_n(reset_n), .inc(inc), .start(start), .stop(stop),
    .clear(clear), .snap(snap), .rd_sel(rd_sel), .rd_data(rd_w),
    .running(run_w), .ovf(ovf_w));
  perf_counter_bank #(.NUM_CH(6), .WIDTH(8), .SATURATE(1), .CYCLE_CH0(0)) u_s (
    .clk(clk), .reset_n(reset_n), .inc(inc), .start(start), .stop(stop),
    .clear(clear), .snap(snap), .rd_sel(rd_sel), .rd_data(rd_s),
    .running(run_s), .ovf(ovf_s));

  logic [63:0] rd_o[3];
  logic        run_o[3];
  logic [5:0]  ovf_o[3];
  always_comb begin
    rd_o[0]  = {32'd0, rd_a};
    rd_o[1]  = {56'd0, rd_w};
    rd_o[2]  = {56'd0, rd_s};
    run_o[0] = run_a;  run_o[1] = run_w;  run_o[2] = run_s;
    ovf_o[0] = ovf_a;  ovf_o[1] = ovf_w;  ovf_o[2] = ovf_s;
  end

  // ---------------- reference model ----------------
  int mw[3]   = '{32, 8, 8};
  int msat[3] = '{0, 0, 1};
  int mcyc[3] = '{1, 1, 0};

  longint unsigned m_cnt[3][6];
  longint unsigned m_sh[3][6];
  longint unsigned m_rd[3];
  bit              m_ovf[3][6];
  int              m_st[3];      // 0 IDLE, 1 RUN, 2 FROZEN

  function automatic longint unsigned lim_of(int d);
    return 64'd1 << mw[d];
  endfunction

  function automatic bit model_go(int d);
    return (m_st[d] == 1) && !clear && !(stop && !start);
  endfunction

  function automatic logic [5:0] ovf_exp(int d);
    logic [5:0] v;
    for (int i = 0; i < 6; i++) v[i] = m_ovf[d][i];
    return v;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < 3; d++) begin
        m_st[d] <= 0;
        m_rd[d] <= 0;
        for (int i = 0; i < 6; i++) begin
          m_cnt[d][i] <= 0; m_sh[d][i] <= 0; m_ovf[d][i] <= 1'b0;
        end
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        m_rd[d] <= (rd_sel < 3'd6) ? m_sh[d][rd_sel] : 64'd0;
        for (int i = 0; i < 6; i++) begin
          if (snap) m_sh[d][i] <= m_cnt[d][i];
          if (clear) begin
            m_cnt[d][i] <= 0;
            m_ovf[d][i] <= 1'b0;
          end else if (model_go(d) && (inc[i] || (i == 0 && mcyc[d] == 1))) begin
            if (m_cnt[d][i] + 1 == lim_of(d)) begin
              m_ovf[d][i] <= 1'b1;
              m_cnt[d][i] <= (msat[d] == 1) ? m_cnt[d][i] : 64'd0;
            end else begin
              m_cnt[d][i] <= m_cnt[d][i] + 1;
            end
          end
        end
        if (clear)                            m_st[d] <= start ? 1 : 0;
        else if (start && !stop)              m_st[d] <= 1;
        else if (stop && !start && m_st[d] == 1) m_st[d] <= 2;
      end
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    inc = '0; start = 0; stop = 0; clear = 0; snap = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_in();
    repeat (2) tick();
    reset_n = 1;
    tick();
    // build up some state, then drop reset mid-cycle
    start = 1; tick(); start = 0;
    inc = 6'h3f; repeat (5) tick(); inc = '0;
    snap = 1; tick(); snap = 0;
    rd_sel = 1; tick();
    #3 reset_n = 0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (rd_o[d] !== 64'd0) begin
        errors++; $display("FAIL reset_rd d%0d: got %0d want 0", d, rd_o[d]);
      end
      checks++;
      if (run_o[d] !== 1'b0) begin
        errors++; $display("FAIL reset_running d%0d: got %0b want 0", d, run_o[d]);
      end
      checks++;
      if (ovf_o[d] !== 6'd0) begin
        errors++; $display("FAIL reset_ovf d%0d: got %0h want 0", d, ovf_o[d]);
      end
    end
    tick();
    reset_n = 1;
    tick();
    start = 1; tick(); start = 0;
    checks++;
    if (run_a !== 1'b1) begin
      errors++; $display("FAIL reset_start_running: got %0b want 1", run_a);
    end
    inc = 6'b000010; repeat (10) tick(); inc = '0;
    stop = 1; tick(); stop = 0;
    checks++;
    if (run_a !== 1'b0) begin
      errors++; $display("FAIL reset_stop_running: got %0b want 0", run_a);
    end
    snap = 1; tick(); snap = 0;
    for (int s = 0; s < 2; s++) begin
      rd_sel = 3'(s); tick();
      checks++;
      if (rd_a !== 32'd10) begin
        errors++; $display("FAIL reset_count ch%0d: got %0d want 10", s, rd_a);
      end
      for (int d = 1; d < 3; d++) begin
        checks++;
        if (rd_o[d] !== m_sh[d][s]) begin
          errors++; $display("FAIL reset_count d%0d ch%0d: got %0d want %0d", d, s, rd_o[d], m_sh[d][s]);
        end
      end
    end
  endtask

  task automatic test_freeze_resume();
    idle_in();
    clear = 1; tick(); clear = 0;
    start = 1; tick(); start = 0;
    repeat (4) tick();
    stop = 1; tick(); stop = 0;
    repeat (3) tick();
    checks++;
    if (run_a !== 1'b0) begin
      errors++; $display("FAIL frozen_running: got %0b want 0", run_a);
    end
    start = 1; tick(); start = 0;
    repeat (5) tick();
    stop = 1; tick(); stop = 0;
    snap = 1; tick(); snap = 0;
    rd_sel = 0; tick();
    checks++;
    if (rd_a !== 32'd9) begin
      errors++; $display("FAIL freeze_resume ch0: got %0d want 9", rd_a);
    end
    checks++;
    if (rd_s !== 8'd0) begin
      errors++; $display("FAIL freeze_resume sat ch0: got %0d want 0", rd_s);
    end
  endtask

  task automatic test_overflow();
    idle_in();
    clear = 1; tick(); clear = 0;
    start = 1; tick(); start = 0;
    inc = 6'b000100; repeat (260) tick(); inc = '0;
    stop = 1; tick(); stop = 0;
    checks++;
    if (ovf_w !== 6'b000101) begin
      errors++; $display("FAIL ovf_wrap flags: got %b want 000101", ovf_w);
    end
    checks++;
    if (ovf_s !== 6'b000100) begin
      errors++; $display("FAIL ovf_sat flags: got %b want 000100", ovf_s);
    end
    checks++;
    if (ovf_a !== 6'b000000) begin
      errors++; $display("FAIL ovf_wide flags: got %b want 000000", ovf_a);
    end
    snap = 1; tick(); snap = 0;
    rd_sel = 2; tick();
    checks++;
    if (rd_w !== 8'd4) begin
      errors++; $display("FAIL ovf_wrap ch2: got %0d want 4", rd_w);
    end
    checks++;
    if (rd_s !== 8'd255) begin
      errors++; $display("FAIL ovf_sat ch2: got %0d want 255", rd_s);
    end
    checks++;
    if (rd_a !== 32'd260) begin
      errors++; $display("FAIL ovf_wide ch2: got %0d want 260", rd_a);
    end
  endtask

  task automatic test_simultaneous();
    idle_in();
    // resume without clearing so overflow flags from the previous test remain
    start = 1; tick(); start = 0;
    inc = 6'b000010; repeat (7) tick(); inc = '0;
    tick();
    snap = 1; clear = 1; start = 1; inc = 6'b000010;
    tick();
    idle_in();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (run_o[d] !== 1'b1) begin
        errors++; $display("FAIL simul_running d%0d: got %0b want 1", d, run_o[d]);
      end
      checks++;
      if (ovf_o[d] !== 6'd0) begin
        errors++; $display("FAIL simul_ovf d%0d: got %b want 0", d, ovf_o[d]);
      end
    end
    rd_sel = 1; tick();
    checks++;
    if (rd_a !== 32'd7) begin
      errors++; $display("FAIL simul_shadow ch1: got %0d want 7", rd_a);
    end
    snap = 1; tick(); snap = 0;
    tick();
    checks++;
    if (rd_a !== 32'd0) begin
      errors++; $display("FAIL simul_live ch1: got %0d want 0", rd_a);
    end
    inc = 6'b000010; tick(); inc = '0;
    snap = 1; tick(); snap = 0;
    tick();
    checks++;
    if (rd_a !== 32'd1) begin
      errors++; $display("FAIL simul_after_inc ch1: got %0d want 1", rd_a);
    end
  endtask

  task automatic test_read_addr();
    longint unsigned prev;
    idle_in();
    for (int k = 0; k < 20; k++) begin
      inc = 6'($urandom); tick();
    end
    idle_in();
    stop = 1; tick(); stop = 0;
    snap = 1; tick(); snap = 0;
    prev = 0;
    for (int s = 0; s < 8; s++) begin
      rd_sel = 3'(s);
      #1;
      if (s > 0) begin
        checks++;
        if (rd_o[0] !== prev) begin
          errors++; $display("FAIL read_latency sel%0d: got %0d want %0d", s, rd_o[0], prev);
        end
      end
      tick();
      for (int d = 0; d < 3; d++) begin
        longint unsigned exp_v;
        exp_v = (s < 6) ? m_sh[d][s] : 64'd0;
        checks++;
        if (rd_o[d] !== exp_v) begin
          errors++; $display("FAIL read_addr d%0d sel%0d: got %0d want %0d", d, s, rd_o[d], exp_v);
        end
        if (d == 0) prev = exp_v;
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      inc    = 6'($urandom);
      start  = ($urandom_range(0, 7) == 0);
      stop   = ($urandom_range(0, 9) == 0);
      clear  = ($urandom_range(0, 39) == 0);
      snap   = ($urandom_range(0, 3) == 0);
      rd_sel = 3'($urandom_range(0, 7));
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (rd_o[d] !== m_rd[d]) begin
          errors++; $display("FAIL rand_rd d%0d cyc%0d: got %0d want %0d", d, k, rd_o[d], m_rd[d]);
        end
        checks++;
        if (run_o[d] !== (m_st[d] == 1)) begin
          errors++; $display("FAIL rand_running d%0d cyc%0d: got %0b want %0b", d, k, run_o[d], m_st[d] == 1);
        end
        checks++;
        if (ovf_o[d] !== ovf_exp(d)) begin
          errors++; $display("FAIL rand_ovf d%0d cyc%0d: got %b want %b", d, k, ovf_o[d], ovf_exp(d));
        end
      end
    end
    idle_in();
  endtask

  initial begin
    test_reset();
    test_freeze_resume();
    test_overflow();
    test_simultaneous();
    test_read_addr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised bank of hardware performance counters for the single-cycle CPU. It generalises the fixed cycle, instruction, memory-access and register-file counters into NUM_CH channels of configurable width, with start/stop/clear control, atomic snapshot, and wrap or saturate overflow. It sits beside the CPU core: event pulses come from the datapath, and benches or a future MMIO port read snapshots through a registered select/read port.

## Interface

- NUM_CH, default 6: number of counter channels, 1–32.
- WIDTH, default 32: counter width in bits, 8–64.
- SATURATE, default 0: 0 means counters wrap to 0 on overflow; 1 means counters hold at all-ones.
- CYCLE_CH0, default 1: 1 means channel 0 counts every clock while running and ignores inc[0].

- clk, input, 1: clock. All state changes on the rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- inc, input, NUM_CH: per-channel event pulses. A channel counts +1 for each cycle its bit is high.
- start, input, 1: begin or resume counting.
- stop, input, 1: freeze counting.
- clear, input, 1: synchronous zero of all counters and overflow flags.
- snap, input, 1: copy all live counters into shadow registers.
- rd_sel, input, max(1,$clog2(NUM_CH)): shadow channel select.
- rd_data, output, WIDTH: registered shadow value of the selected channel.
- running, output, 1: high in state RUN.
- ovf, output, NUM_CH: sticky per-channel overflow flags.

## Operation

- **States**
  - IDLE: the reset state. Counters hold.
  - RUN: counting.
  - FROZEN: counters hold and keep their values.
- **Transitions**, evaluated in priority order:
  - clear: counters and ovf go to 0. Next state is RUN if start, else IDLE. stop is ignored.
  - start and stop both high: state is unchanged.
  - start: IDLE or FROZEN goes to RUN.
  - stop: RUN goes to FROZEN.
  - No command: state holds.
- **Counting in RUN**
  - Channel i is incremented when inc[i] is high.
  - With CYCLE_CH0=1, channel 0 is incremented every RUN cycle.
  - In IDLE and FROZEN, inc is ignored.
- **Overflow**, on an increment from all-ones:
  - SATURATE=0: the counter becomes 0 and ovf[i] is set.
  - SATURATE=1: the counter stays all-ones and ovf[i] is set.
  - ovf[i] is sticky and is cleared only by clear or reset.
- **Snapshot**
  - snap loads all shadow[i] with the live counter values as they were before this cycle's update.
  - This holds even when increment or clear happens in the same cycle, so the capture is atomic across channels.
  - Shadows are unaffected by clear. They are zeroed only by reset.
- **Readout**
  - rd_data is assigned shadow[rd_sel] at each edge.
  - If rd_sel ≥ NUM_CH, rd_data is 0.
  - Live counters are not directly readable. Software snaps, then reads.

## Timing

- Reset is asynchronous. On reset_n low, immediately and regardless of clk:
  - state goes to IDLE.
  - all counters, shadows, ovf and rd_data go to 0.
  - running goes to 0.
- Reset release takes effect at the first rising edge where reset_n is high.
- Command latency: a start sampled at edge t gives running=1 after edge t.
  - An inc sampled at edge t+1 is the first inc counted.
  - The first counted cycle for CYCLE_CH0 is also edge t+1.
- stop sampled at edge t: increments at edge t are not applied, and running=0 after edge t.
- Read latency: rd_sel sampled at edge t gives rd_data valid after edge t. One cycle of latency, one read per cycle.
- snap at edge t: shadows are updated after edge t, and a read issued at edge t+1 returns the new value.
- Reset asserted mid-run: all state is lost and nothing is preserved.

## Test plan

- **Reset:** hold reset_n=0 mid-cycle, then release, pulse start, and drive inc[1] high for 10 cycles before stop.
  - Expected: ch0=10, ch1=10.
  - Expected: running goes 1 then 0.
  - Expected: all outputs read 0 during reset.
- **Freeze/resume:** start, then 4 cycles, stop, 3 idle cycles, start, 5 cycles, stop, snap, read rd_sel=0.
  - Expected: rd_data=9 one cycle after rd_sel.
- **Overflow:** WIDTH=8, inc[2] for 260 cycles.
  - With SATURATE=0, expected: ch2=4 and ovf[2]=1.
  - Rerun with SATURATE=1, expected: ch2=255 and ovf[2]=1.
- **Simultaneous events:** with ch1=7, in one cycle assert snap, clear and start with inc[1]=1.
  - Expected: shadow[1]=7.
  - Expected: live ch1=0 and ovf=0.
  - Expected: running=1.
  - Expected: ch1=1 after the next inc.
- **Read addressing:** with NUM_CH=6, read rd_sel=0..7 after a snap.
  - Expected: shadow values for selects 0..5.
  - Expected: 0 for selects 6 and 7.
  - Expected: each value lands exactly one cycle after its select.
- **CPU integration:** the relu program on the CPU, with inc wired to instr, mem_read, mem_write, rf_read and rf_write, and start at reset release.
  - Expected: snapshot values match the CPU's legacy counters at cycle 25.
